// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Slot entries track in-flight destination registers from EX through WB.
package hazard_pkg;

   localparam int SLOT_AW = 8;
   localparam int FWD_RF  = 0;

   typedef struct packed {
      logic               valid;
      logic               wr;
      logic [SLOT_AW-1:0] addr;
      logic               is_load;
   } slot_t;

   // First slot index whose result register holds usable data.
   function automatic int ready_slot(input logic is_load,
                                     input int   load_lat);
      return is_load ? 2 + load_lat : 2;
   endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority matcher: youngest in-flight writer of one source register.
// Returns a load-use hazard flag or the forward select for that source.
import hazard_pkg::*;

module hazard_src_match #(
   parameter int NUM_STAGES = 3,
   parameter int LOAD_LAT   = 1,
   parameter int REG_AW     = 5,
   parameter int FW         = $clog2(NUM_STAGES + 1)
) (
   input  slot_t [NUM_STAGES:1] slots_i,
   input  logic [REG_AW-1:0]    src_i,
   input  logic                 use_i,
   output logic                 hazard_o,
   output logic [FW-1:0]        fwd_sel_o
);

   logic hit;
   logic hit_load;
   int   k_hit;

   always_comb begin
      hit      = 1'b0;
      hit_load = 1'b0;
      k_hit    = 0;
      // Oldest to youngest so the smallest matching slot wins.
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (slots_i[k].valid && slots_i[k].wr &&
             slots_i[k].addr == SLOT_AW'(src_i)) begin
            hit      = 1'b1;
            hit_load = slots_i[k].is_load;
            k_hit    = k;
         end
      end
   end

   always_comb begin
      hazard_o  = 1'b0;
      fwd_sel_o = FW'(FWD_RF);
      if (use_i && src_i != '0 && hit &&
          k_hit + 1 <= NUM_STAGES) begin
         if (k_hit + 1 < ready_slot(hit_load, LOAD_LAT)) begin
            hazard_o = 1'b1;
         end else begin
            fwd_sel_o = FW'(k_hit + 1);
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control for the in-order pipeline.
// Define HAZARD_PERF_EN to add stall/flush cycle counters.
import hazard_pkg::*;

module hazard_scoreboard #(
   parameter int NUM_STAGES = 3,
   parameter int LOAD_LAT   = 1,
   parameter int REG_AW     = 5,
   parameter int FW         = $clog2(NUM_STAGES + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_use_rs_i,
   input  logic              id_use_rt_i,
   input  logic              id_wr_i,
   input  logic [REG_AW-1:0] id_wr_addr_i,
   input  logic              id_is_load_i,
   input  logic              mem_busy_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              bubble_o,
   output logic [FW-1:0]     fwd_rs_o,
   output logic [FW-1:0]     fwd_rt_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       stall_cycles_o,
   output logic [31:0]       flush_cycles_o
`endif
);

   slot_t [NUM_STAGES:1] slots_q, slots_d;
   logic [FW-1:0]        fwd_rs_q, fwd_rs_d;
   logic [FW-1:0]        fwd_rt_q, fwd_rt_d;

   logic          haz_rs, haz_rt;
   logic [FW-1:0] sel_rs, sel_rt;
   logic          stall;
   logic          issue;
   slot_t         id_entry;

   hazard_src_match #(
      .NUM_STAGES (NUM_STAGES),
      .LOAD_LAT   (LOAD_LAT),
      .REG_AW     (REG_AW),
      .FW         (FW)
   ) u_match_rs (
      .slots_i   (slots_q),
      .src_i     (id_rs_i),
      .use_i     (id_use_rs_i),
      .hazard_o  (haz_rs),
      .fwd_sel_o (sel_rs)
   );

   hazard_src_match #(
      .NUM_STAGES (NUM_STAGES),
      .LOAD_LAT   (LOAD_LAT),
      .REG_AW     (REG_AW),
      .FW         (FW)
   ) u_match_rt (
      .slots_i   (slots_q),
      .src_i     (id_rt_i),
      .use_i     (id_use_rt_i),
      .hazard_o  (haz_rt),
      .fwd_sel_o (sel_rt)
   );

   // A flush squashes the ID instruction, so it never stalls.
   assign stall = id_valid_i & (haz_rs | haz_rt) & ~flush_i;
   assign issue = id_valid_i & ~stall & ~flush_i;

   assign stall_o      = stall;
   assign pc_write_o   = ~(stall | mem_busy_i);
   assign ifid_write_o = ~(stall | mem_busy_i);
   assign bubble_o     = (stall | flush_i) & ~mem_busy_i;
   assign fwd_rs_o     = fwd_rs_q;
   assign fwd_rt_o     = fwd_rt_q;

   always_comb begin
      id_entry         = '0;
      id_entry.valid   = 1'b1;
      id_entry.wr      = id_wr_i;
      id_entry.addr    = SLOT_AW'(id_wr_addr_i);
      id_entry.is_load = id_is_load_i;
   end

   always_comb begin
      slots_d  = slots_q;
      fwd_rs_d = fwd_rs_q;
      fwd_rt_d = fwd_rt_q;
      if (!mem_busy_i) begin
         for (int k = NUM_STAGES; k >= 2; k--) begin
            slots_d[k] = slots_q[k-1];
         end
         slots_d[1] = issue ? id_entry : '0;
         fwd_rs_d   = issue ? sel_rs : FW'(FWD_RF);
         fwd_rt_d   = issue ? sel_rt : FW'(FWD_RF);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         slots_q  <= '0;
         fwd_rs_q <= '0;
         fwd_rt_q <= '0;
      end else begin
         slots_q  <= slots_d;
         fwd_rs_q <= fwd_rs_d;
         fwd_rt_q <= fwd_rt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating so long runs never wrap back to small values.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((stall | mem_busy_i) && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (flush_i && !mem_busy_i && flush_cnt_q != 32'hFFFF_FFFF) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cnt_q;
   assign flush_cycles_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with queued expectations.
// Honours HAZARD_PERF_EN for the optional cycle counters.
module tb_hazard_scoreboard;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       id_valid_i = 1'b0;
   logic [4:0] id_rs_i = '0;
   logic [4:0] id_rt_i = '0;
   logic       id_use_rs_i = 1'b0;
   logic       id_use_rt_i = 1'b0;
   logic       id_wr_i = 1'b0;
   logic [4:0] id_wr_addr_i = '0;
   logic       id_is_load_i = 1'b0;
   logic       mem_busy_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       stall_o, pc_write_o, ifid_write_o, bubble_o;
   logic [1:0] fwd_rs_o, fwd_rt_o;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_o, flush_cycles_o;
`endif

   hazard_scoreboard dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .id_valid_i   (id_valid_i),
      .id_rs_i      (id_rs_i),
      .id_rt_i      (id_rt_i),
      .id_use_rs_i  (id_use_rs_i),
      .id_use_rt_i  (id_use_rt_i),
      .id_wr_i      (id_wr_i),
      .id_wr_addr_i (id_wr_addr_i),
      .id_is_load_i (id_is_load_i),
      .mem_busy_i   (mem_busy_i),
      .flush_i      (flush_i),
      .stall_o      (stall_o),
      .pc_write_o   (pc_write_o),
      .ifid_write_o (ifid_write_o),
      .bubble_o     (bubble_o),
      .fwd_rs_o     (fwd_rs_o),
      .fwd_rt_o     (fwd_rt_o)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles_o (stall_cycles_o),
      .flush_cycles_o (flush_cycles_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string nm;
      bit    chk;
      bit    st, pw, bb;
      int    frs, frt;
      bit    chkp;
      int    sc, fc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   bit   p_chk = 1'b0;
   int   p_sc = 0;
   int   p_fc = 0;

   task automatic cmp(input string nm, input string fld,
                      input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s.%s got=%0d want=%0d", nm, fld, act, req);
      end
   endtask

   // Monitor: one expectation per cycle, checked mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               cmp(e.nm, "stall", stall_o, e.st);
               cmp(e.nm, "pc_write", pc_write_o, e.pw);
               cmp(e.nm, "ifid_write", ifid_write_o, e.pw);
               cmp(e.nm, "bubble", bubble_o, e.bb);
               cmp(e.nm, "fwd_rs", fwd_rs_o, e.frs);
               cmp(e.nm, "fwd_rt", fwd_rt_o, e.frt);
            end
`ifdef HAZARD_PERF_EN
            if (e.chkp) begin
               cmp(e.nm, "stall_cycles", stall_cycles_o, e.sc);
               cmp(e.nm, "flush_cycles", flush_cycles_o, e.fc);
            end
`else
            if (e.chkp) total = total + 0;
`endif
         end
      end
   end

   task automatic cyc(input string nm, input bit rst, input bit v,
                      input int rs, input bit urs,
                      input int rt, input bit urt,
                      input bit wr, input int wa, input bit ld,
                      input bit busy, input bit fl, input bit chk,
                      input bit es, input bit ep, input bit eb,
                      input int efs, input int eft);
      exp_t e;
      @(posedge clk_i);
      #1;
      rst_i        = rst;
      id_valid_i   = v;
      id_rs_i      = rs[4:0];
      id_use_rs_i  = urs;
      id_rt_i      = rt[4:0];
      id_use_rt_i  = urt;
      id_wr_i      = wr;
      id_wr_addr_i = wa[4:0];
      id_is_load_i = ld;
      mem_busy_i   = busy;
      flush_i      = fl;
      e.nm  = nm;
      e.chk = chk;
      e.st  = es;
      e.pw  = ep;
      e.bb  = eb;
      e.frs = efs;
      e.frt = eft;
      e.chkp = p_chk;
      e.sc  = p_sc;
      e.fc  = p_fc;
      exp_q.push_back(e);
      p_chk = 1'b0;
   endtask

   initial begin
      //     name       rst v  rs u  rt u  wr wa ld bsy fl chk st pw bb frs frt
      cyc("reset",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      p_chk = 1; p_sc = 0; p_fc = 0;
      cyc("idle",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("add3",       1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("sub_rs3",    1, 1, 3, 1, 1, 1, 1, 6, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("sub_ex",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0);
      cyc("lw4",        1, 1, 2, 1, 0, 0, 1, 4, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("lu_stall",   1, 1, 1, 1, 4, 1, 1, 7, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      cyc("lu_issue",   1, 1, 1, 1, 4, 1, 1, 7, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("lu_ex",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3);
      cyc("w5a",        1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("w5b",        1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("rd5",        1, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("rd5_ex",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 2);
      cyc("lw0",        1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("rd0",        1, 1, 0, 1, 0, 1, 1, 9, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("rd0_ex",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("lw8",        1, 1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("busy0",      1, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
      cyc("busy1",      1, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
      cyc("busy2",      1, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
      cyc("busy_rel",   1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      p_chk = 1; p_sc = 5; p_fc = 0;
      cyc("busy_iss",   1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("busy_ex",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3, 0);
      cyc("lw9",        1, 1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("flush_haz",  1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0);
      p_chk = 1; p_sc = 5; p_fc = 1;
      cyc("w10",        1, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("lw11_rd10",  1, 1, 10, 1, 0, 0, 1, 11, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("rst_stall",  0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      p_chk = 1; p_sc = 0; p_fc = 0;
      cyc("post_rst",   1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("post_ex",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk_i);
         #1;
      end
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
